// File: rtl/wide_arith_sequencer.sv
// Multi-precision ADD/SUB/INC/DEC front end: streams one N-bit slice per cycle,
// LS word first, through an external N-bit adder and chains the carry in a register.
module wide_arith_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [N*WORDS-1:0]   a_in,
  input  logic [N*WORDS-1:0]   b_in,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 zero,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic                 alu_carry_in,
  output logic [1:0]           alu_select,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_carry_out
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_t;

  state_t                    state_q, state_d;
  logic [WORDS-1:0][N-1:0]   a_q, a_d;
  logic [WORDS-1:0][N-1:0]   bm_q, bm_d;
  logic [WORDS-1:0][N-1:0]   result_q, result_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      carry_out_q, carry_out_d;
  logic                      overflow_q, overflow_d;
  logic                      zero_q, zero_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    bm_d         = bm_q;
    result_d     = result_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    carry_out_d  = carry_out_q;
    overflow_d   = overflow_q;
    zero_d       = zero_q;
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a_in;
          idx_d   = '0;
          // Subtraction and inc/dec are folded into the B operand and carry seed.
          unique case (op_t'(op))
            OP_ADD: begin bm_d = b_in;  carry_d = 1'b0; end
            OP_SUB: begin bm_d = ~b_in; carry_d = 1'b1; end
            OP_INC: begin bm_d = '0;    carry_d = 1'b1; end
            OP_DEC: begin bm_d = '1;    carry_d = 1'b0; end
          endcase
        end
      end

      S_RUN: begin
        alu_a           = a_q[idx_q];
        alu_b           = bm_q[idx_q];
        alu_carry_in    = carry_q;
        result_d[idx_q] = alu_result;
        carry_d         = alu_carry_out;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d     = S_DONE;
          idx_d       = '0;
          carry_out_d = alu_carry_out;
          overflow_d  = (a_q[WORDS-1][N-1] == bm_q[WORDS-1][N-1]) &&
                        (alu_result[N-1] != a_q[WORDS-1][N-1]);
          zero_d      = (result_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      bm_q        <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bm_q        <= bm_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign carry_out  = carry_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;
  assign alu_select = 2'b00;

endmodule
